// File: rtl/dpram_core_pkg.sv
// Shared constants, state encoding and helpers for the dual-port RAM multiply core.
package dpram_core_pkg;

   localparam logic [7:0] OFF_CTRL = 8'd0;
   localparam logic [7:0] OFF_A    = 8'd1;
   localparam logic [7:0] OFF_B    = 8'd2;
   localparam logic [7:0] OFF_RLO  = 8'd3;
   localparam logic [7:0] OFF_RHI  = 8'd4;

   localparam int BIT_START  = 0;
   localparam int BIT_BUSY   = 1;
   localparam int BIT_DONE   = 2;
   localparam int BIT_SIGNED = 3;

   localparam logic [15:0] ST_BUSY = 16'h0002;
   localparam logic [15:0] ST_DONE = 16'h0004;

   localparam logic [3:0] MUL_LAST = 4'd15;

   typedef enum logic [3:0] {
      S_IDLE,
      S_POLL,
      S_ACK,
      S_RD_A,
      S_RD_B,
      S_CAP_B,
      S_MUL,
      S_NEG,
      S_WR_LO,
      S_WR_HI,
      S_FIN
   } state_e;

   // Magnitude of a two's-complement word; 16'h8000 maps to 32768, which still fits unsigned.
   function automatic logic [15:0] mag16(input logic [15:0] v);
      return v[15] ? (~v + 16'd1) : v;
   endfunction

endpackage

// File: rtl/seq_mult16.sv
// 16x16 unsigned shift-add multiplier: a start pulse loads operands, done marks the last of 16 add cycles.
module seq_mult16
   import dpram_core_pkg::*;
(
   input  logic        clk,
   input  logic        resetq,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        done,
   output logic [31:0] product
);

   logic [31:0] mcand_q, mcand_d;
   logic [15:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q, run_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start) begin
         mcand_d  = {16'h0000, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mplier_d = mplier_q >> 1;
         mcand_d  = mcand_q << 1;
         // Counter holds at its last value rather than wrapping back to zero.
         if (cnt_q == MUL_LAST) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

   assign done    = run_q && (cnt_q == MUL_LAST);
   assign product = acc_q;

endmodule

// File: rtl/dpram_mult_core.sv
// Port-2 RAM compute core: polls a control word, multiplies two operands, writes result and DONE back.
// Optional signed operation is enabled with `define DPRAM_MULT_SIGNED_EN.
module dpram_mult_core
   import dpram_core_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
   input  logic              clk,
   input  logic              resetq,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   output logic              rd,
   output logic              wr,
   output logic              busy
);

   state_e      state_q, state_d;
   logic        armed_q;
   logic        rd_prev_q;
   logic [15:0] a_q, a_d;

   logic        mult_start;
   logic [15:0] mult_a, mult_b;
   logic        mult_done;
   logic [31:0] mult_product;
   logic [31:0] result;

`ifdef DPRAM_MULT_SIGNED_EN
   logic        sgn_q, sgn_d;
   logic        neg_q, neg_d;
   logic [31:0] res_q, res_d;
`endif

   seq_mult16 u_mult (
      .clk     (clk),
      .resetq  (resetq),
      .start   (mult_start),
      .a       (mult_a),
      .b       (mult_b),
      .done    (mult_done),
      .product (mult_product)
   );

   // armed_q keeps rd low in the first IDLE after reset; rd_prev_q rejects a POLL whose read never issued.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      addr       = BASE_ADDR;
      d_out      = '0;
      rd         = 1'b0;
      wr         = 1'b0;
      busy       = 1'b0;
      mult_start = 1'b0;
      mult_a     = a_q;
      mult_b     = d_in;
      result     = mult_product;
`ifdef DPRAM_MULT_SIGNED_EN
      sgn_d      = sgn_q;
      neg_d      = neg_q;
      res_d      = res_q;
      if (sgn_q) begin
         result = res_q;
      end
`endif
      case (state_q)
         S_IDLE: begin
            rd      = armed_q;
            state_d = S_POLL;
         end
         S_POLL: begin
            if (rd_prev_q && d_in[BIT_START]) begin
`ifdef DPRAM_MULT_SIGNED_EN
               sgn_d = d_in[BIT_SIGNED];
`endif
               state_d = S_ACK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACK: begin
            wr      = 1'b1;
            busy    = 1'b1;
            d_out   = ST_BUSY;
            state_d = S_RD_A;
         end
         S_RD_A: begin
            rd      = 1'b1;
            busy    = 1'b1;
            addr    = BASE_ADDR + ADDR_W'(OFF_A);
            state_d = S_RD_B;
         end
         S_RD_B: begin
            rd      = 1'b1;
            busy    = 1'b1;
            addr    = BASE_ADDR + ADDR_W'(OFF_B);
            a_d     = d_in;
            state_d = S_CAP_B;
         end
         S_CAP_B: begin
            busy       = 1'b1;
            mult_start = 1'b1;
`ifdef DPRAM_MULT_SIGNED_EN
            neg_d = 1'b0;
            if (sgn_q) begin
               mult_a = mag16(a_q);
               mult_b = mag16(d_in);
               neg_d  = a_q[15] ^ d_in[15];
            end
`endif
            state_d = S_MUL;
         end
         S_MUL: begin
            busy = 1'b1;
            if (mult_done) begin
`ifdef DPRAM_MULT_SIGNED_EN
               state_d = sgn_q ? S_NEG : S_WR_LO;
`else
               state_d = S_WR_LO;
`endif
            end
         end
`ifdef DPRAM_MULT_SIGNED_EN
         S_NEG: begin
            busy    = 1'b1;
            res_d   = neg_q ? (~mult_product + 32'd1) : mult_product;
            state_d = S_WR_LO;
         end
`endif
         S_WR_LO: begin
            wr      = 1'b1;
            busy    = 1'b1;
            addr    = BASE_ADDR + ADDR_W'(OFF_RLO);
            d_out   = result[15:0];
            state_d = S_WR_HI;
         end
         S_WR_HI: begin
            wr      = 1'b1;
            busy    = 1'b1;
            addr    = BASE_ADDR + ADDR_W'(OFF_RHI);
            d_out   = result[31:16];
            state_d = S_FIN;
         end
         S_FIN: begin
            wr      = 1'b1;
            busy    = 1'b1;
            d_out   = ST_DONE;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q   <= S_IDLE;
         armed_q   <= 1'b0;
         rd_prev_q <= 1'b0;
         a_q       <= '0;
`ifdef DPRAM_MULT_SIGNED_EN
         sgn_q     <= 1'b0;
         neg_q     <= 1'b0;
         res_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         armed_q   <= 1'b1;
         rd_prev_q <= rd;
         a_q       <= a_d;
`ifdef DPRAM_MULT_SIGNED_EN
         sgn_q     <= sgn_d;
         neg_q     <= neg_d;
         res_q     <= res_d;
`endif
      end
   end

endmodule

// File: tb/tb_dpram_mult_core.sv
// Scoreboard bench for dpram_mult_core: a CPU model writes operands on port 1, results are checked at each DONE write.
module tb_dpram_mult_core;

   localparam logic [7:0] BASE = 8'h00;

   logic        clk = 1'b0;
   logic        resetq = 1'b0;
   logic [7:0]  addr;
   logic [15:0] d_in, d_out;
   logic        rd, wr, busy;

   logic [15:0] mem [0:255];
   logic [15:0] ram_q;
   logic        cpu_we = 1'b0;
   logic [7:0]  cpu_addr = 8'h00;
   logic [15:0] cpu_data = 16'h0000;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      int          lat;
   } exp_t;
   exp_t sbQ[$];

   int   ackCnt = 0;
   int   finCnt = 0;
   int   ackCyc = 0;
   bit   inOp = 1'b0;
   bit   monEn = 1'b0;
   bit   isAck, isFin;
   exp_t e;

   dpram_mult_core #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(BASE)) dut (
      .clk    (clk),
      .resetq (resetq),
      .addr   (addr),
      .d_in   (d_in),
      .d_out  (d_out),
      .rd     (rd),
      .wr     (wr),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   assign d_in = ram_q;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr) mem[addr] <= d_out;
      if (cpu_we) mem[cpu_addr] <= cpu_data;
      if (rd) ram_q <= mem[addr];
   end

   task automatic checkResult(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cpuWrite(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      cpu_we   = 1'b1;
      cpu_addr = a;
      cpu_data = d;
      @(negedge clk);
      cpu_we   = 1'b0;
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit sgn);
      exp_t x;
      logic [31:0] p;
      x.lat = 22;
      p = {16'h0000, a} * {16'h0000, b};
`ifdef DPRAM_MULT_SIGNED_EN
      if (sgn) begin
         p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
         x.lat = 23;
      end
`endif
      x.lo = p[15:0];
      x.hi = p[31:16];
      sbQ.push_back(x);
      cpuWrite(BASE + 8'd1, a);
      cpuWrite(BASE + 8'd2, b);
      cpuWrite(BASE, sgn ? 16'h0009 : 16'h0001);
   endtask

   task automatic waitFin(input int budget);
      int startCnt;
      int n;
      startCnt = finCnt;
      n = 0;
      while (finCnt == startCnt && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (finCnt == startCnt) checkResult("fin_timeout", 32'd0, 32'd1);
      @(negedge clk);
      checkResult("ctrl_done", mem[BASE], 32'h0004);
   endtask

   // Monitor: busy window tracking, rd/wr exclusion and scoreboard pop on each DONE write.
   always @(negedge clk) begin
      if (!resetq) begin
         inOp = 1'b0;
      end else if (monEn) begin
         isAck = wr && (addr == BASE) && (d_out == 16'h0002);
         isFin = wr && (addr == BASE) && (d_out == 16'h0004);
         if (isAck) begin
            inOp   = 1'b1;
            ackCyc = cyc;
            ackCnt++;
         end
         checkResult("busy", busy, inOp);
         checkResult("rd_wr_excl", rd & wr, 32'd0);
         if (isFin) begin
            if (sbQ.size() == 0) begin
               checkResult("sb_unexpected", 32'd1, 32'd0);
            end else begin
               e = sbQ.pop_front();
               checkResult("res_lo", mem[BASE + 8'd3], e.lo);
               checkResult("res_hi", mem[BASE + 8'd4], e.hi);
               checkResult("latency", cyc - ackCyc, e.lat);
            end
            inOp = 1'b0;
            finCnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int  nToggleErr, nWr, nBusy, startAck, n;
      logic prevRd;

      resetq = 1'b0;
      for (int i = 0; i < 5; i++) cpuWrite(BASE + 8'(i), 16'h0000);
      checkResult("rst_addr", addr, BASE);
      checkResult("rst_dout", d_out, 32'h0);
      checkResult("rst_rd", rd, 32'h0);
      checkResult("rst_wr", wr, 32'h0);
      checkResult("rst_busy", busy, 32'h0);
      @(negedge clk);
      resetq = 1'b1;
      monEn  = 1'b1;

      // Idle with START clear: reads only, rd alternates every cycle.
      repeat (3) @(negedge clk);
      prevRd = rd;
      nToggleErr = 0; nWr = 0; nBusy = 0;
      repeat (100) begin
         @(negedge clk);
         if (rd == prevRd) nToggleErr++;
         if (wr) nWr++;
         if (busy) nBusy++;
         prevRd = rd;
      end
      checkResult("idle_rd_toggle", nToggleErr, 32'd0);
      checkResult("idle_wr", nWr, 32'd0);
      checkResult("idle_busy", nBusy, 32'd0);

      applyStimulus(16'd3, 16'd5, 1'b0);
      waitFin(200);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
      waitFin(200);

      // Abort in the tenth MUL cycle; previous results must survive.
      startAck = ackCnt;
      cpuWrite(BASE + 8'd1, 16'h1111);
      cpuWrite(BASE + 8'd2, 16'h2222);
      cpuWrite(BASE, 16'h0001);
      n = 0;
      while (ackCnt == startAck && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ackCnt == startAck) checkResult("abort_ack_timeout", 32'd0, 32'd1);
      repeat (13) @(posedge clk);
      #2 resetq = 1'b0;
      #1;
      checkResult("abort_rd", rd, 32'h0);
      checkResult("abort_wr", wr, 32'h0);
      checkResult("abort_busy", busy, 32'h0);
      checkResult("abort_addr", addr, BASE);
      checkResult("abort_dout", d_out, 32'h0);
      repeat (2) @(negedge clk);
      checkResult("abort_rlo", mem[BASE + 8'd3], 32'h0001);
      checkResult("abort_rhi", mem[BASE + 8'd4], 32'hFFFE);
      resetq = 1'b1;

      applyStimulus(16'd7, 16'd9, 1'b0);
      waitFin(200);
      applyStimulus(16'd0, 16'd1234, 1'b0);
      waitFin(200);
      applyStimulus(16'h8000, 16'h0002, 1'b0);
      waitFin(200);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
         waitFin(200);
      end
      applyStimulus(16'hFFFE, 16'h0003, 1'b1);
      waitFin(200);

      checkResult("sb_drained", sbQ.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dpram_mult_core.md
Name: dpram_mult_core

Overview:
- Peripheral compute core on port 2 of the dual-port RAM. The J1 CPU uses port 1.
- Polls a control word in the RAM. When software sets the start bit, the core reads two 16-bit operands and computes a 32-bit product with a sequential shift-add multiplier.
- Writes the result and a done status back into the RAM, so the CPU sees results only through the shared RAM.

Parameters:
- BASE_ADDR, 8'h00, port-2 address of the control/status word. Operand A is at BASE+1, operand B at BASE+2, result low at BASE+3, result high at BASE+4.
- DATA_W, 16, operand and RAM word width. Only 16 is supported.
- ADDR_W, 8, RAM address width.

Ports:
- clk  in  1  system clock, rising edge
- resetq  in  1  asynchronous reset, active-low
- addr  out  ADDR_W  RAM port-2 address
- d_in  in  DATA_W  RAM port-2 read data
- d_out  out  DATA_W  RAM port-2 write data
- rd  out  1  RAM port-2 read strobe
- wr  out  1  RAM port-2 write strobe
- busy  out  1  high from ACK through FIN

Behaviour:
- RAM contract: synchronous read. d_in is valid in the cycle after rd is high with addr. A write commits on the clock edge where wr is high.
- Invariant: rd and wr are never high in the same cycle.
- Reset (resetq low, asynchronous):
  - state=IDLE.
  - addr=BASE_ADDR, d_out=0, rd=0, wr=0, busy=0.
  - Operand, product and counter registers are cleared.
  - Reset mid-operation aborts the operation with no further writes. The RAM contents are left as they were.
- Control word bits: bit0 START (written by the CPU), bit1 BUSY, bit2 DONE, bit3 SIGNED (used only with the optional feature).
- States, one cycle each unless stated:
  - IDLE: rd=1, addr=BASE. Go to POLL.
  - POLL: if d_in[0]=1, latch d_in[3] and go to ACK; else go to IDLE. Polling therefore repeats every 2 cycles.
  - ACK: wr=1, addr=BASE, d_out=16'h0002. This clears START and sets BUSY. Go to RD_A.
  - RD_A: rd=1, addr=BASE+1. Go to RD_B.
  - RD_B: rd=1, addr=BASE+2. Capture A from d_in. Go to CAP_B.
  - CAP_B: capture B from d_in, clear the 32-bit accumulator, counter=0. Go to MUL.
  - MUL: 16 cycles. Each cycle, if multiplier LSB=1, add the shifted multiplicand into the accumulator. Then shift the multiplier right and the multiplicand left. Exit to WR_LO when counter=15; the counter is 4 bits and does not wrap.
  - WR_LO: wr=1, addr=BASE+3, d_out=P[15:0].
  - WR_HI: wr=1, addr=BASE+4, d_out=P[31:16].
  - FIN: wr=1, addr=BASE, d_out=16'h0004 (DONE=1, BUSY=0). Go to IDLE.
- Latency: 23 cycles from the POLL cycle that sees START to the FIN write, inclusive of FIN.
- Arithmetic: unsigned 16x16 -> 32. No overflow is possible.
- Collisions: software must not write BASE..BASE+4 while BUSY=1. A START written while BUSY is overwritten by the FIN write and is lost.
- DONE stays set until software clears it. A new START is accepted whether or not DONE is set. The ACK write clears DONE.
- Idle with START=0: the core only reads, and wr stays 0 indefinitely.

Optional Feature:
- Macro: DPRAM_MULT_SIGNED_EN.
- Defined:
  - If the latched SIGNED bit is 1, A and B are two's-complement.
  - The core multiplies their magnitudes and negates the 32-bit product when the signs differ.
  - Negation adds one cycle between MUL and WR_LO, so latency becomes 24 cycles for signed operations only.
  - Status writes preserve SIGNED=0.
- Undefined: bit3 is ignored and all operations are unsigned with 23-cycle latency.

Decomposition:
- Package dpram_core_pkg holds:
  - address offsets OFF_CTRL, OFF_A, OFF_B, OFF_RLO, OFF_RHI;
  - status bit indices and the status constants ST_BUSY=16'h0002 and ST_DONE=16'h0004;
  - the state encoding.
- Sub-module seq_mult16: start/done handshake with a 16-cycle shift-add datapath, owning the accumulator and counter.
- The top level keeps the FSM and RAM sequencing.

Test Plan:
- Preload A=3, B=5, CTRL=1 -> RAM[3]=16'h000F, RAM[4]=16'h0000, RAM[0]=16'h0004. The FIN write occurs 23 cycles after the START-seeing POLL.
- A=16'hFFFF, B=16'hFFFF -> RAM[3]=16'h0001, RAM[4]=16'hFFFE.
- CTRL=0 held for 100 cycles -> wr never asserted, busy=0. rd toggles with period 2.
- resetq pulsed low during MUL (cycle 10) -> outputs return to reset values asynchronously and RAM[3..4] are unchanged. A new START then completes correctly (A=7, B=9 -> 16'h003F).
- Back-to-back: after DONE, write A=0, B=1234, CTRL=1 -> result 0, and DONE is reasserted. Assertion checks: rd&wr never both 1, and busy=1 exactly from ACK through FIN.
- With DPRAM_MULT_SIGNED_EN: A=16'hFFFE (-2), B=3, CTRL=16'h0009 -> RAM[3]=16'hFFFA, RAM[4]=16'hFFFF, 24-cycle latency.
